// File: rtl/sfx_pkg.sv
// Shared types and clip table defaults for the sound-effect scheduler.
package sfx_pkg;

    localparam int unsigned N_SRC      = 4;
    localparam int unsigned SFX_ADDR_W = 16;
    localparam int unsigned SFX_DATA_W = 16;
    localparam int unsigned SFX_ID_W   = 2;

    // One ROM address per source; element 0 is the highest-priority source.
    typedef logic [N_SRC-1:0][SFX_ADDR_W-1:0] clip_tbl_t;

    localparam clip_tbl_t CLIP_BASE = {16'd5760, 16'd3840, 16'd1920, 16'd0};
    localparam clip_tbl_t CLIP_LEN  = {4{16'd1920}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

endpackage

// File: rtl/sfx_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module sfx_prio_enc
    import sfx_pkg::*;
#(
    parameter int unsigned N = N_SRC,
    parameter int unsigned W = SFX_ID_W
) (
    input  logic [N-1:0] req,
    output logic         any,
    output logic [W-1:0] idx
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                any = 1'b1;
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: latches triggers, arbitrates by priority and plays
// one clip at a time from the shared sample ROM, one held sample per period.
module sfx_scheduler
    import sfx_pkg::*;
#(
    parameter int unsigned HOLD_TIME     = 31_250,
    parameter clip_tbl_t   CLIP_BASE_TBL = CLIP_BASE,
    parameter clip_tbl_t   CLIP_LEN_TBL  = CLIP_LEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_SRC-1:0]             trig,
    input  logic                         mute,
    output logic [SFX_ADDR_W-1:0]        rom_addr,
    input  logic signed [SFX_DATA_W-1:0] rom_data,
    output logic signed [SFX_DATA_W-1:0] sample_out,
    output logic                         sample_strobe,
    output logic                         busy,
    output logic [SFX_ID_W-1:0]          active_id
);

    localparam int unsigned CNT_W = (HOLD_TIME > 1) ? $clog2(HOLD_TIME) : 1;

    state_t                       state, state_nx;
    logic [N_SRC-1:0]             pend, pend_nx, pend_clr_c;
    logic [CNT_W-1:0]             time_cnt, time_nx;
    logic [SFX_ADDR_W-1:0]        addr_nx, clip_last_c;
    logic signed [SFX_DATA_W-1:0] sample_nx;
    logic                         strobe_nx;
    logic [SFX_ID_W-1:0]          id_nx;
    logic                         win_any_c, grant_c, boundary_c;
    logic [SFX_ID_W-1:0]          win_idx_c;

    sfx_prio_enc #(
        .N (N_SRC),
        .W (SFX_ID_W)
    ) u_prio_enc (
        .req (pend),
        .any (win_any_c),
        .idx (win_idx_c)
    );

    // Next-state, grant and output decisions.
    always_comb begin
        state_nx    = state;
        time_nx     = time_cnt;
        addr_nx     = rom_addr;
        sample_nx   = sample_out;
        strobe_nx   = 1'b0;
        id_nx       = active_id;
        grant_c     = 1'b0;
        pend_clr_c  = '0;
        clip_last_c = CLIP_BASE_TBL[active_id] + CLIP_LEN_TBL[active_id] - SFX_ADDR_W'(1);
        boundary_c  = (time_cnt == CNT_W'(HOLD_TIME - 1));

        case (state)
            IDLE: begin
                sample_nx = '0;
                addr_nx   = '0;
                time_nx   = '0;
                if (win_any_c && !mute) grant_c = 1'b1;
            end
            LOAD: begin
                state_nx = PLAY;
                time_nx  = '0;
            end
            PLAY: begin
                time_nx = boundary_c ? '0 : time_cnt + 1'b1;
                if (boundary_c) begin
                    if (mute) begin
                        state_nx  = IDLE;
                        sample_nx = '0;
                        addr_nx   = '0;
                    end else begin
                        sample_nx = rom_data;
                        strobe_nx = 1'b1;
                        // Lowest pending index at or above our priority preempts/retriggers.
                        if (win_any_c && (win_idx_c <= active_id)) begin
                            grant_c = 1'b1;
                        end else if (rom_addr == clip_last_c) begin
                            if (win_any_c) begin
                                grant_c = 1'b1;
                            end else begin
                                state_nx = IDLE;
                                addr_nx  = '0;
                            end
                        end else begin
                            addr_nx = rom_addr + 1'b1;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        if (grant_c) begin
            state_nx              = LOAD;
            addr_nx               = CLIP_BASE_TBL[win_idx_c];
            id_nx                 = win_idx_c;
            pend_clr_c[win_idx_c] = 1'b1;
        end

        // A trigger landing with a grant of the same bit keeps the bit set.
        pend_nx = mute ? '0 : ((pend & ~pend_clr_c) | trig);
    end

    // State, pending and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pend          <= '0;
            time_cnt      <= '0;
            rom_addr      <= '0;
            sample_out    <= '0;
            sample_strobe <= 1'b0;
            busy          <= 1'b0;
            active_id     <= '0;
        end else begin
            state         <= state_nx;
            pend          <= pend_nx;
            time_cnt      <= time_nx;
            rom_addr      <= addr_nx;
            sample_out    <= sample_nx;
            sample_strobe <= strobe_nx;
            busy          <= (state_nx != IDLE);
            active_id     <= id_nx;
        end
    end

endmodule

// File: tb/tb_sfx_scheduler.sv
// Scoreboard bench for sfx_scheduler with a clip-level reference model.
module tb_sfx_scheduler;
    import sfx_pkg::*;

    localparam int unsigned HOLD    = 4;
    localparam int          LEN     = 3;
    localparam clip_tbl_t   TB_BASE = {16'd24, 16'd16, 16'd8, 16'd0};
    localparam clip_tbl_t   TB_LEN  = {4{16'd3}};
    localparam int          BASE [4] = '{0, 8, 16, 24};

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [3:0]         trig = 4'b0;
    logic               mute = 1'b0;
    logic [15:0]        rom_addr;
    logic signed [15:0] rom_data = '0;
    logic signed [15:0] sample_out;
    logic               sample_strobe;
    logic               busy;
    logic [1:0]         active_id;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Reference model state: clip being played and the edge of its next sample.
    bit       m_busy = 1'b0;
    int       m_id   = 0;
    int       m_off  = 0;
    int       m_bnd  = 0;
    bit [3:0] m_pend = 4'b0;

    typedef struct {
        int data;
        int cyc;
    } exp_t;
    exp_t sbq[$];

    sfx_scheduler #(
        .HOLD_TIME     (HOLD),
        .CLIP_BASE_TBL (TB_BASE),
        .CLIP_LEN_TBL  (TB_LEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .trig          (trig),
        .mute          (mute),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .sample_out    (sample_out),
        .sample_strobe (sample_strobe),
        .busy          (busy),
        .active_id     (active_id)
    );

    always #5 clk = ~clk;

    // Sample ROM: data equals address, one clock of read latency.
    always @(posedge clk) rom_data <= $signed(rom_addr);

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int lowest(input bit [3:0] p);
        for (int i = 0; i < 4; i++) if (p[i]) return i;
        return -1;
    endfunction

    // Reference model, evaluated at every rising edge with the inputs of the ending cycle.
    always @(posedge clk) begin
        int       w;
        int       g;
        bit [3:0] clr;
        cyc++;
        if (rst) begin
            m_busy = 1'b0;
            m_pend = 4'b0;
            m_off  = 0;
            m_id   = 0;
        end else begin
            w   = lowest(m_pend);
            g   = -1;
            clr = 4'b0;
            if (!m_busy) begin
                if (w >= 0 && !mute) g = w;
            end else if (cyc == m_bnd) begin
                if (mute) begin
                    m_busy = 1'b0;
                end else begin
                    sbq.push_back('{data: BASE[m_id] + m_off, cyc: cyc});
                    if (w >= 0 && w <= m_id) g = w;
                    else if (m_off == LEN - 1) begin
                        if (w >= 0) g = w;
                        else m_busy = 1'b0;
                    end else begin
                        m_off++;
                        m_bnd = cyc + int'(HOLD);
                    end
                end
            end
            if (g >= 0) begin
                m_busy = 1'b1;
                m_id   = g;
                m_off  = 0;
                m_bnd  = cyc + 1 + int'(HOLD);
                clr[g] = 1'b1;
            end
            m_pend = mute ? 4'b0 : ((m_pend & ~clr) | trig);
        end
    end

    // Monitor: compares DUT outputs against the scoreboard away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                chk("strobe", int'(sample_strobe), 1);
                chk("sample", int'(sample_out), e.data);
            end else begin
                chk("no_strobe", int'(sample_strobe), 0);
            end
            chk("busy", int'(busy), int'(m_busy));
            if (m_busy) begin
                chk("active_id", int'(active_id), m_id);
                chk("rom_addr", int'(rom_addr), BASE[m_id] + m_off);
            end else begin
                chk("rom_addr_idle", int'(rom_addr), 0);
                if (!sample_strobe) chk("sample_idle", int'(sample_out), 0);
            end
        end
    end

    task automatic pulse(input logic [3:0] t);
        @(negedge clk);
        trig = t;
        @(negedge clk);
        trig = 4'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int mute_cnt;
        mute_cnt = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_sample", int'(sample_out), 0);
        chk("rst_strobe", int'(sample_strobe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_active_id", int'(active_id), 0);
        chk_en = 1'b1;

        // Single clip.
        pulse(4'b0100);
        wait_cyc(20);
        chk("t1_busy_end", int'(busy), 0);
        chk("t1_sample_end", int'(sample_out), 0);

        // Priority preemption during the first sample of clip 3.
        pulse(4'b1000);
        wait_cyc(2);
        pulse(4'b0001);
        wait_cyc(25);

        // Low priority waits for the running clip.
        pulse(4'b0001);
        wait_cyc(6);
        pulse(4'b0010);
        wait_cyc(35);

        // Retrigger restarts the clip.
        pulse(4'b0010);
        wait_cyc(3);
        pulse(4'b0010);
        wait_cyc(25);

        // Mute aborts and drops triggers seen meanwhile.
        pulse(4'b0001);
        wait_cyc(5);
        mute = 1'b1;
        pulse(4'b0100);
        wait_cyc(6);
        mute = 1'b0;
        wait_cyc(20);

        // Reset mid-clip, then simultaneous triggers.
        pulse(4'b0001);
        wait_cyc(6);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rom_addr", int'(rom_addr), 0);
        chk("midrst_sample", int'(sample_out), 0);
        chk("midrst_strobe", int'(sample_strobe), 0);
        chk("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        pulse(4'b0110);
        wait_cyc(35);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            trig = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            if (mute_cnt > 0) mute_cnt--;
            else if ($urandom_range(0, 149) == 0) mute_cnt = int'($urandom_range(1, 12));
            mute = (mute_cnt > 0);
            rst  = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        trig = 4'b0;
        mute = 1'b0;
        rst  = 1'b0;
        wait_cyc(40);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
